// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, size defaults and length check.
package loader_pkg;

    localparam int unsigned LOADER_ADDR_W = 7;
    localparam int unsigned LOADER_DEPTH  = 32;
    localparam int unsigned LOADER_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LEN  = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_CHECK     = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    function automatic logic len_valid(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Pin-side byte/strobe inputs and RAM write port of the program loader.
interface prog_loader_if
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DATA_W = LOADER_DATA_W
);
    logic              strobe_in;
    logic [DATA_W-1:0] byte_in;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;

    modport master (output strobe_in, output byte_in,
                    input  mem_addr,  input  mem_data, input mem_we);
    modport slave  (input  strobe_in, input  byte_in,
                    output mem_addr,  output mem_data, output mem_we);
endinterface

// File: rtl/prog_loader_strobe_sync.sv
// Two-flop synchronizer for an asynchronous pin followed by a one-cycle rising-edge pulse.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed program from pins into RAM, holding the CPU until the load is done.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before release.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = LOADER_ADDR_W,
    parameter int unsigned DEPTH  = LOADER_DEPTH,
    parameter int unsigned DATA_W = LOADER_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start,
    prog_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_run
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_run_q, cpu_run_d;
    logic              strobe_rise;
    logic              last_word;

    strobe_sync u_strobe_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.strobe_in),
        .rise     (strobe_rise)
    );

    assign last_word = (32'(index_q) + 32'd1) == 32'(len_q);

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (load_start) chk_d = '0;
        else if (state_q == S_WAIT_DATA && strobe_rise) chk_d = chk_q ^ bus.byte_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_q <= '0;
        else        chk_q <= chk_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // load_start outranks any strobe edge detected in the same cycle
    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = S_WAIT_LEN;
        end else begin
            case (state_q)
                S_WAIT_LEN:
                    if (strobe_rise)
                        state_d = len_valid(32'(bus.byte_in), DEPTH) ? S_WAIT_DATA : S_ERROR;
                S_WAIT_DATA:
                    if (mem_we_q && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK:
                    if (strobe_rise)
                        state_d = (bus.byte_in == chk_q) ? S_DONE : S_ERROR;
`endif
                default: ;
            endcase
        end
    end

    // index advances in the cycle after each write, alongside mem_we dropping
    always_comb begin
        index_d    = index_q;
        len_d      = len_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        if (load_start) begin
            index_d = '0;
        end else begin
            case (state_q)
                S_WAIT_LEN:
                    if (strobe_rise) begin
                        len_d   = bus.byte_in;
                        index_d = '0;
                    end
                S_WAIT_DATA:
                    if (strobe_rise) begin
                        mem_addr_d = index_q;
                        mem_data_d = bus.byte_in;
                        mem_we_d   = 1'b1;
                    end else if (mem_we_q && !last_word) begin
                        index_d = index_q + ADDR_W'(1);
                    end
                default: ;
            endcase
        end
        busy_d    = (state_d == S_WAIT_LEN) || (state_d == S_WAIT_DATA);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERROR);
        cpu_run_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q    <= '0;
            len_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_run_q  <= 1'b0;
        end else begin
            index_q    <= index_d;
            len_q      <= len_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_run_q  <= cpu_run_d;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_we   = mem_we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_run      = cpu_run_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: randomized and directed loads against a protocol-level model.
`timescale 1ns/1ps
module tb_prog_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic busy, done, err, cpu_run;

    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader #(
        .ADDR_W (LOADER_ADDR_W),
        .DEPTH  (LOADER_DEPTH),
        .DATA_W (LOADER_DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_run    (cpu_run)
    );

    typedef enum {M_IDLE, M_LEN, M_DATA, M_CHECK, M_DONE, M_ERR} phase_e;
    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t        exp_q[$];
    phase_e     m_ph = M_IDLE;
    int         m_left = 0;
    int         m_addr = 0;
    logic [7:0] m_xor = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Protocol-level reference: what a byte arriving now should do.
    function automatic void model_byte(input logic [7:0] b, input int c);
        case (m_ph)
            M_LEN:
                if (b == 8'd0 || int'(b) > LOADER_DEPTH) begin
                    m_ph = M_ERR;
                end else begin
                    m_left = int'(b);
                    m_addr = 0;
                    m_ph   = M_DATA;
                end
            M_DATA: begin
                exp_q.push_back('{m_addr, int'(b), c + 3});
                m_xor = m_xor ^ b;
                m_addr++;
                m_left--;
                if (m_left == 0) begin
`ifdef LOADER_CHECKSUM_EN
                    m_ph = M_CHECK;
`else
                    m_ph = M_DONE;
`endif
                end
            end
            M_CHECK: m_ph = (b == m_xor) ? M_DONE : M_ERR;
            default: ;
        endcase
    endfunction

    function automatic void model_load();
        m_ph  = M_LEN;
        m_xor = 8'h00;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (bus.mem_we) begin
                chk("we_width", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), e.addr);
                    chk("wr_data", 32'(bus.mem_data), e.data);
                    chk("wr_latency", cyc, e.cyc);
                end
            end
            prev_we = bus.mem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.byte_in   = b;
        bus.strobe_in = 1'b1;
        model_byte(b, cyc);
        repeat (4) @(negedge clk);
        bus.strobe_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        model_load();
    endtask

    // Strobe whose detected edge lands in the same cycle as load_start.
    task automatic collide(input logic [7:0] b);
        @(negedge clk);
        bus.byte_in   = b;
        bus.strobe_in = 1'b1;
        repeat (2) @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        model_load();
        repeat (2) @(negedge clk);
        bus.strobe_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic finish_prog();
`ifdef LOADER_CHECKSUM_EN
        send_byte(m_xor);
`endif
    endtask

    task automatic check_status(input string name);
        chk({name, "/busy"}, 32'(busy), 32'(m_ph == M_LEN || m_ph == M_DATA));
        chk({name, "/done"}, 32'(done), 32'(m_ph == M_DONE));
        chk({name, "/err"}, 32'(err), 32'(m_ph == M_ERR));
        chk({name, "/cpu_run"}, 32'(cpu_run), 32'(m_ph == M_DONE));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "/mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({name, "/mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({name, "/mem_data"}, 32'(bus.mem_data), 32'd0);
        chk({name, "/busy"}, 32'(busy), 32'd0);
        chk({name, "/done"}, 32'(done), 32'd0);
        chk({name, "/err"}, 32'(err), 32'd0);
        chk({name, "/cpu_run"}, 32'(cpu_run), 32'd0);
    endtask

    initial begin
        bus.strobe_in = 1'b0;
        bus.byte_in   = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_byte(8'h05);
        check_status("idle_ignore");

        pulse_load();
        check_status("after_load_start");
        send_byte(8'h03);
        send_byte(8'h13);
        send_byte(8'h93);
        send_byte(8'h37);
        finish_prog();
        check_status("normal");

        send_byte(8'h44);
        send_byte(8'h55);
        check_status("done_ignore");

        pulse_load();
        send_byte(8'h00);
        check_status("len_zero");
        pulse_load();
        send_byte(8'h21);
        check_status("len_33");
        pulse_load();
        send_byte(8'h01);
        send_byte(8'hAA);
        finish_prog();
        check_status("len_one");

        pulse_load();
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        finish_prog();
        check_status("full_depth");

        pulse_load();
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_load();
        send_byte(8'h02);
        check_status("abort_len");
        send_byte(8'h55);
        send_byte(8'h66);
        finish_prog();
        check_status("abort");

        pulse_load();
        send_byte(8'h03);
        send_byte(8'h01);
        collide(8'h99);
        check_status("collide");
        send_byte(8'h01);
        send_byte(8'h77);
        finish_prog();
        check_status("after_collide");

`ifdef LOADER_CHECKSUM_EN
        pulse_load();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        check_status("csum_good");
        pulse_load();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        check_status("csum_bad");
`endif

        for (int t = 0; t < 16; t++) begin
            int unsigned len;
            pulse_load();
            if ($urandom_range(0, 7) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
            else
                len = $urandom_range(1, 32);
            send_byte(8'(len));
            if (len >= 1 && len <= 32) begin
                for (int k = 0; k < int'(len); k++) send_byte(8'($urandom_range(0, 255)));
`ifdef LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) send_byte(m_xor ^ 8'($urandom_range(1, 255)));
                else send_byte(m_xor);
`endif
            end
            if ($urandom_range(0, 1) == 0) send_byte(8'($urandom_range(0, 255)));
            check_status("random");
        end

        pulse_load();
        send_byte(8'h04);
        send_byte(8'hA1);
        @(negedge clk);
        bus.byte_in   = 8'hB2;
        bus.strobe_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("inflight_we", 32'(bus.mem_we), 32'd1);
        chk("inflight_addr", 32'(bus.mem_addr), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_ph = M_IDLE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.strobe_in = 1'b0;
        repeat (4) @(negedge clk);
        check_status("post_reset");

        repeat (4) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side front end for the CPU's 32-word program RAM.
- Receives program bytes from the chip's input pins using a strobe-qualified parallel byte protocol.
- Writes each byte into consecutive RAM words through the RAM's write port (mem address, data byte, write enable).
- Holds the CPU halted until the load completes, then releases it by raising cpu_run, so RAM writes and instruction fetches never overlap.

Parameters:
- ADDR_W, 7, width of the RAM write address.
- DEPTH, 32, number of RAM words; largest accepted program length.
- DATA_W, 8, width of one program byte.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  synchronous one-cycle pulse; begins or restarts a load.
- strobe_in  in  1  asynchronous byte strobe from pins; each rising edge presents one byte.
- byte_in  in  DATA_W  byte from pins; must be stable from strobe rise until 3 clk edges later.
- mem_addr  out  ADDR_W  RAM write word address.
- mem_data  out  DATA_W  RAM write data; the RAM zero-extends it to 32 bits.
- mem_we  out  1  RAM write enable; one-cycle pulse per byte.
- busy  out  1  high in WAIT_LEN and WAIT_DATA.
- done  out  1  high in DONE.
- err  out  1  high in ERROR.
- cpu_run  out  1  CPU enable; high only in DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, synchronizer flops 0. RAM contents are not touched.
- Strobe path: 2-flop synchronizer, then rising-edge detect (edge = s2 & ~s2_d).
  - Raw rise before edge 1 gives edge=1 between edges 2 and 3.
  - Any register update caused by a byte occurs at edge 3.
- All outputs are registered.
- States:
  - IDLE: wait for load_start, then go to WAIT_LEN.
  - WAIT_LEN: on edge, latch len = byte_in.
    - len = 0 or len > DEPTH: go to ERROR.
    - Otherwise: index = 0, go to WAIT_DATA.
  - WAIT_DATA: on edge, register mem_addr = index, mem_data = byte_in, mem_we = 1.
    - mem_we drops the next cycle; index increments in that same cycle.
    - After the write of index len-1: go to DONE, with done = 1 and cpu_run = 1 registered in the same cycle mem_we drops.
  - DONE: hold done and cpu_run. load_start clears cpu_run and done on the next edge and goes to WAIT_LEN.
  - ERROR: hold err = 1 and cpu_run = 0. load_start clears err and goes to WAIT_LEN.
- Write latency: raw strobe rise to mem_we high = 3 clk edges. mem_we is exactly 1 cycle wide.
- Minimum strobe spacing: 4 clk cycles high and 4 low; faster strobes are undefined.
- load_start during WAIT_LEN or WAIT_DATA aborts the load:
  - index = 0, state = WAIT_LEN.
  - An in-flight mem_we pulse still completes.
  - Words already written are kept.
- Edges arriving in IDLE, DONE or ERROR are ignored. No write occurs in those states.
- load_start and an edge in the same cycle: load_start wins and the edge is dropped.
- Asynchronous reset mid-load: immediately mem_we = 0 and cpu_run = 0, state IDLE. A partial program remains in RAM.
- index range is 0..DEPTH-1; it never wraps because len ≤ DEPTH.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the len data bytes, one extra byte is received in a CHECK state.
  - It is compared with the XOR of all data bytes (XOR accumulator cleared on load_start).
  - Match: go to DONE. Mismatch: go to ERROR, cpu_run stays 0.
  - No RAM write occurs for the checksum byte.
- Undefined:
  - No CHECK state and no accumulator.
  - The FSM goes directly from the last data write to DONE.

Decomposition:
- Shared package loader_pkg holds:
  - State encoding constants: IDLE=0, WAIT_LEN=1, WAIT_DATA=2, CHECK=3, DONE=4, ERROR=5.
  - Defaults for DEPTH, ADDR_W and DATA_W.
- One natural sub-module: strobe_sync (2-flop synchronizer plus rising-edge pulse, with async active-low reset). It is reusable for other pin inputs.
- The FSM and write datapath stay in prog_loader.

Test Plan:
- Normal load: load_start, then bytes 0x03, 0x13, 0x93, 0x37 → mem_we pulses at addr 0,1,2 with data 0x13,0x93,0x37; each pulse 1 cycle and 3 edges after its strobe rise; done = 1 and cpu_run = 1 after the third write.
- Bad length: len byte 0x00, and separately 0x21 → err = 1, no mem_we, cpu_run = 0; load_start then len 0x01, byte 0xAA → write at addr 0, err cleared, done = 1.
- Full depth: len 0x20 with 32 bytes 0x00..0x1F → last write addr 31, data 0x1F; no write to addr 32.
- Abort and reset: len 5, 2 bytes, then load_start → next byte goes to WAIT_LEN as len, not to addr 2; separately, assert rst_n low during WAIT_DATA → all outputs 0 asynchronously and state IDLE.
- Ignore and collision: strobes while in DONE → no mem_we, cpu_run stays 1; load_start in the same cycle as a detected edge → edge dropped, state WAIT_LEN.
- LOADER_CHECKSUM_EN: bytes 0x12, 0x34 with checksum 0x26 → done = 1; with checksum 0x27 → err = 1, cpu_run = 0, only 2 writes.
